pixel_stream_tx: RTL and testbench
==================================

Name: pixel_stream_tx

Overview:
- Transmit end of the grayscale pixel-stream interface consumed by the 3x3 window line buffer.
- Accepts raster-order gray pixels from the upstream converter over a valid/ready handshake and tracks column and row position.
- Drives pixel/edge/valid toward the line buffer, one pixel per accepted beat.
- At end of frame, injects zero-valued flush rows so the buffer drains the last image row through its centre tap, then signals frame completion.

Parameters:
- DATA_WIDTH, 12, gray pixel width.
- PIXEL_LENGTH, 640, pixels per row (columns).
- FRAME_ROWS, 480, image rows per frame.
- FLUSH_ROWS, 1, zero rows emitted after the last image row.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_pixel  input  DATA_WIDTH  upstream gray pixel.
- in_valid  input  1  upstream beat valid.
- in_sof  input  1  start of frame, qualified by in_valid; marks the pixel at row 0, col 0.
- in_ready  output  1  block can accept a beat this cycle.
- pixel_out  output  DATA_WIDTH  pixel to the line buffer.
- pixel_edge  output  1  pixel_out is in col 0 or col PIXEL_LENGTH-1.
- pixel_valid  output  1  pixel_out/pixel_edge are valid; the line buffer shifts on it.
- col  output  clog2(PIXEL_LENGTH)  column of the current pixel_out.
- row  output  clog2(FRAME_ROWS+FLUSH_ROWS)  row of the current pixel_out; flush rows continue numbering after FRAME_ROWS-1.
- busy  output  1  state is not IDLE.
- frame_done  output  1  one-cycle pulse when the flush completes.
- resync_err  output  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE.
  - pixel_out, pixel_edge, pixel_valid, col, row, frame_done and resync_err are all 0.
  - Internal counters clear.
  - Reset mid-frame or mid-flush abandons the frame; no frame_done is produced.
- Accepted beat: in_valid & in_ready.
- All outputs are registered. Latency from an accepted beat to pixel_valid=1 is exactly 1 cycle. pixel_valid=0 on cycles with no accepted beat and no flush.
- Output fields for each emitted pixel:
  - pixel_edge = (col==0) | (col==PIXEL_LENGTH-1), computed from that pixel's own column.
  - col and row hold the emitted pixel's coordinates.
- State IDLE:
  - in_ready=1.
  - A beat with in_sof=0 is accepted and discarded; no output is produced.
  - A beat with in_sof=1 is emitted as (row 0, col 0); go to STREAM; next pixel position is col 1, row 0.
- State STREAM:
  - in_ready=1.
  - Each accepted beat is emitted at the current position, then the position advances.
  - Column wraps from PIXEL_LENGTH-1 to 0 and row increments.
  - When the accepted beat is (FRAME_ROWS-1, PIXEL_LENGTH-1), go to FLUSH with position (FRAME_ROWS, 0).
  - in_sof=1 on an accepted beat in STREAM (any position, including col 0 of a new row): pulse resync_err, emit the beat as (0,0) of a new frame, restart counters. No flush or frame_done for the abandoned frame.
  - Gaps (in_valid=0) hold the counters unchanged; no timeout.
- State FLUSH:
  - in_ready=0.
  - Emit FLUSH_ROWS*PIXEL_LENGTH pixels on consecutive cycles: pixel_out=0, pixel_valid=1, pixel_edge and col/row per the counters.
  - The cycle after the final flush pixel is registered, pulse frame_done=1 for one cycle and go to IDLE.
  - in_valid/in_sof are ignored in FLUSH.
  - With FLUSH_ROWS=0, go directly to DONE behaviour: frame_done pulses the cycle after the last image pixel is emitted.
- frame_done and resync_err are never asserted in the same cycle.
- Counter widths are sized for the parameters; no overflow is possible within a legal frame.

Test Plan:
- Parameters for all scenarios: PIXEL_LENGTH=4, FRAME_ROWS=3, FLUSH_ROWS=1.
- Reset then one full frame of 12 back-to-back beats, values 1..12, sof on the first → pixel_out 1..12 one cycle after each beat, then 4 zeros with in_ready=0, then frame_done=1 exactly 17 cycles after the first accept; pixel_edge pattern 1,0,0,1 repeating over all 16 pixels.
- In IDLE, 3 beats with in_sof=0 (values 7,8,9), then a sof beat with value 5 → no pixel_valid for 7/8/9; first output is 5 at col=0, row=0.
- Full frame with in_valid toggling 1,0,1,0 → pixel_valid mirrors accepts with 1-cycle lag; col/row sequence is unaffected; total of 16 pixel_valid pulses.
- sof asserted on the 6th beat (row 1, col 1) → resync_err pulses once; that pixel is emitted as row 0, col 0; a subsequent 12-beat frame completes with a single frame_done.
- rst pulsed low during the 2nd flush cycle → outputs are 0 immediately (asynchronously); no frame_done; the next sof frame restarts at (0,0).
- FLUSH_ROWS=0 variant with a 12-beat frame → in_ready is never deasserted; frame_done pulses the cycle after pixel 12 is emitted.

Source files
------------

// File: rtl/pixel_stream_tx_if.sv
// Grayscale pixel-stream bundle: upstream valid/ready beat plus the
// pixel/edge/valid/position stream toward the 3x3 window line buffer.
`timescale 1ns/1ps
interface pixel_stream_tx_if #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned PIXEL_LENGTH = 640,
  parameter int unsigned FRAME_ROWS   = 480,
  parameter int unsigned FLUSH_ROWS   = 1
);
  localparam int unsigned COL_W = (PIXEL_LENGTH > 1) ? $clog2(PIXEL_LENGTH) : 1;
  localparam int unsigned ROW_W = ((FRAME_ROWS + FLUSH_ROWS) > 1) ?
                                  $clog2(FRAME_ROWS + FLUSH_ROWS) : 1;

  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  in_valid;
  logic                  in_sof;
  logic                  in_ready;

  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  pixel_edge;
  logic                  pixel_valid;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;

  // Environment side: upstream source and line-buffer sink
  modport master (
    output in_pixel, in_valid, in_sof,
    input  in_ready, pixel_out, pixel_edge, pixel_valid, col, row
  );

  // Transmitter side
  modport slave (
    input  in_pixel, in_valid, in_sof,
    output in_ready, pixel_out, pixel_edge, pixel_valid, col, row
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// Pixel-stream transmitter: tracks raster position of accepted gray pixels,
// re-emits them one cycle later and appends zero flush rows at end of frame.
`timescale 1ns/1ps
module pixel_stream_tx #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned PIXEL_LENGTH = 640,
  parameter int unsigned FRAME_ROWS   = 480,
  parameter int unsigned FLUSH_ROWS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  pixel_stream_tx_if.slave  bus,
  output logic              busy,
  output logic              frame_done,
  output logic              resync_err
);
  localparam int unsigned COL_W = (PIXEL_LENGTH > 1) ? $clog2(PIXEL_LENGTH) : 1;
  localparam int unsigned ROW_W = ((FRAME_ROWS + FLUSH_ROWS) > 1) ?
                                  $clog2(FRAME_ROWS + FLUSH_ROWS) : 1;

  localparam logic [COL_W-1:0] LAST_COL       = COL_W'(PIXEL_LENGTH - 1);
  localparam logic [ROW_W-1:0] LAST_IMG_ROW   = ROW_W'(FRAME_ROWS - 1);
  localparam logic [ROW_W-1:0] LAST_FLUSH_ROW = ROW_W'(FRAME_ROWS + FLUSH_ROWS - 1);
  localparam logic [ROW_W-1:0] FLUSH_ROW0     = ROW_W'(FRAME_ROWS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state,     w_state_nxt;
  logic [COL_W-1:0]      r_col_pos,   w_col_pos_nxt;
  logic [ROW_W-1:0]      r_row_pos,   w_row_pos_nxt;
  logic [DATA_WIDTH-1:0] r_pixel,     w_pixel_nxt;
  logic                  r_edge,      w_edge_nxt;
  logic                  r_valid,     w_valid_nxt;
  logic [COL_W-1:0]      r_col,       w_col_nxt;
  logic [ROW_W-1:0]      r_row,       w_row_nxt;
  logic                  r_done,      w_done_nxt;
  logic                  r_resync,    w_resync_nxt;
  logic                  r_in_ready;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_take;
  logic [COL_W-1:0]      w_emit_col;
  logic [ROW_W-1:0]      w_emit_row;
  logic                  w_at_last_col;
  logic                  w_at_last_img;
  logic                  w_at_last_flush;
  logic                  w_emit_edge;
  logic [COL_W-1:0]      w_adv_col;
  logic [ROW_W-1:0]      w_adv_row;

  // A sof beat is always placed at (0,0), whatever the running position is
  assign w_accept        = bus.in_valid & r_in_ready;
  assign w_take          = w_accept & (bus.in_sof | (r_state == S_STREAM));
  assign w_emit_col      = (w_accept && bus.in_sof) ? '0 : r_col_pos;
  assign w_emit_row      = (w_accept && bus.in_sof) ? '0 : r_row_pos;
  assign w_at_last_col   = (w_emit_col == LAST_COL);
  assign w_at_last_img   = w_at_last_col && (w_emit_row == LAST_IMG_ROW);
  assign w_at_last_flush = w_at_last_col && (w_emit_row == LAST_FLUSH_ROW);
  assign w_emit_edge     = (w_emit_col == '0) | w_at_last_col;
  assign w_adv_col       = w_at_last_col ? '0 : w_emit_col + COL_W'(1);
  assign w_adv_row       = w_at_last_col ? w_emit_row + ROW_W'(1) : w_emit_row;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_col_pos_nxt = r_col_pos;
    w_row_pos_nxt = r_row_pos;
    w_pixel_nxt   = r_pixel;
    w_edge_nxt    = r_edge;
    w_valid_nxt   = 1'b0;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_done_nxt    = 1'b0;
    w_resync_nxt  = 1'b0;

    case (r_state)
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        w_pixel_nxt = '0;
        w_valid_nxt = 1'b1;
        w_edge_nxt  = w_emit_edge;
        w_col_nxt   = w_emit_col;
        w_row_nxt   = w_emit_row;
        if (w_at_last_flush) begin
          w_state_nxt   = S_DONE;
          w_col_pos_nxt = '0;
          w_row_pos_nxt = '0;
        end else begin
          w_col_pos_nxt = w_adv_col;
          w_row_pos_nxt = w_adv_row;
        end
      end
      S_IDLE, S_STREAM: ;
      default: w_state_nxt = S_IDLE;
    endcase

    // Image beat: emitted at its position; sof inside STREAM restarts the frame
    if (w_take) begin
      w_pixel_nxt  = bus.in_pixel;
      w_valid_nxt  = 1'b1;
      w_edge_nxt   = w_emit_edge;
      w_col_nxt    = w_emit_col;
      w_row_nxt    = w_emit_row;
      w_resync_nxt = bus.in_sof && (r_state == S_STREAM);
      if (w_at_last_img) begin
        w_state_nxt   = (FLUSH_ROWS > 0) ? S_FLUSH : S_DONE;
        w_col_pos_nxt = '0;
        w_row_pos_nxt = (FLUSH_ROWS > 0) ? FLUSH_ROW0 : '0;
      end else begin
        w_state_nxt   = S_STREAM;
        w_col_pos_nxt = w_adv_col;
        w_row_pos_nxt = w_adv_row;
      end
    end
  end

  // State, position and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_col_pos  <= '0;
      r_row_pos  <= '0;
      r_pixel    <= '0;
      r_edge     <= 1'b0;
      r_valid    <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_done     <= 1'b0;
      r_resync   <= 1'b0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col_pos  <= w_col_pos_nxt;
      r_row_pos  <= w_row_pos_nxt;
      r_pixel    <= w_pixel_nxt;
      r_edge     <= w_edge_nxt;
      r_valid    <= w_valid_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_done     <= w_done_nxt;
      r_resync   <= w_resync_nxt;
      r_in_ready <= (w_state_nxt != S_FLUSH);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.pixel_out   = r_pixel;
  assign bus.pixel_edge  = r_edge;
  assign bus.pixel_valid = r_valid;
  assign bus.col         = r_col;
  assign bus.row         = r_row;
  assign busy            = r_busy;
  assign frame_done      = r_done;
  assign resync_err      = r_resync;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed, table-driven bench for pixel_stream_tx on a 4x3 frame, with one
// instance using a single flush row and one with no flush rows.
`timescale 1ns/1ps
module tb_pixel_stream_tx;
  localparam int unsigned DW = 12;
  localparam int unsigned PL = 4;
  localparam int unsigned FR = 3;

  typedef struct {
    logic          valid;
    logic          sof;
    logic [DW-1:0] pix;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ep;
    logic          ee;
    logic [1:0]    ec;
    logic [1:0]    er;
    logic          ed;
    logic          ers;
  } vec_t;

  typedef struct {
    logic          valid;
    logic [DW-1:0] pix;
    logic          edg;
    logic [1:0]    col;
    logic [1:0]    row;
    logic          done;
    logic          resync;
    logic          ready;
    logic          busy;
  } obs_t;

  logic clk;
  logic rst;
  logic busy_f1, done_f1, resync_f1;
  logic busy_f0, done_f0, resync_f0;
  int   checks;
  int   failures;
  int   tbl_valid_cnt;
  vec_t tbl[$];

  pixel_stream_tx_if #(.DATA_WIDTH(DW), .PIXEL_LENGTH(PL), .FRAME_ROWS(FR),
                       .FLUSH_ROWS(1)) bus_f1 ();
  pixel_stream_tx_if #(.DATA_WIDTH(DW), .PIXEL_LENGTH(PL), .FRAME_ROWS(FR),
                       .FLUSH_ROWS(0)) bus_f0 ();

  pixel_stream_tx #(.DATA_WIDTH(DW), .PIXEL_LENGTH(PL), .FRAME_ROWS(FR),
                    .FLUSH_ROWS(1)) dut (
    .clk(clk), .rst(rst), .bus(bus_f1.slave),
    .busy(busy_f1), .frame_done(done_f1), .resync_err(resync_f1)
  );

  pixel_stream_tx #(.DATA_WIDTH(DW), .PIXEL_LENGTH(PL), .FRAME_ROWS(FR),
                    .FLUSH_ROWS(0)) dut_nf (
    .clk(clk), .rst(rst), .bus(bus_f0.slave),
    .busy(busy_f0), .frame_done(done_f0), .resync_err(resync_f0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic s,
                       input logic [DW-1:0] p);
    if (sel) begin
      bus_f0.in_valid = v; bus_f0.in_sof = s; bus_f0.in_pixel = p;
    end else begin
      bus_f1.in_valid = v; bus_f1.in_sof = s; bus_f1.in_pixel = p;
    end
  endtask

  task automatic sample(input bit sel, output obs_t o);
    if (sel) begin
      o.valid = bus_f0.pixel_valid; o.pix = bus_f0.pixel_out;
      o.edg = bus_f0.pixel_edge; o.col = bus_f0.col; o.row = bus_f0.row;
      o.done = done_f0; o.resync = resync_f0; o.ready = bus_f0.in_ready;
      o.busy = busy_f0;
    end else begin
      o.valid = bus_f1.pixel_valid; o.pix = bus_f1.pixel_out;
      o.edg = bus_f1.pixel_edge; o.col = bus_f1.col; o.row = bus_f1.row;
      o.done = done_f1; o.resync = resync_f1; o.ready = bus_f1.in_ready;
      o.busy = busy_f1;
    end
  endtask

  function automatic void add_beat(input bit sof, input logic [DW-1:0] pix,
                                   input int c, input int r, input bit rs);
    vec_t v;
    v.valid = 1'b1; v.sof = sof; v.pix = pix; v.rdy = 1'b1;
    v.ev = 1'b1; v.ep = pix; v.ee = (c == 0) || (c == PL - 1);
    v.ec = 2'(c); v.er = 2'(r); v.ed = 1'b0; v.ers = rs;
    tbl.push_back(v);
  endfunction

  function automatic void add_drop(input logic [DW-1:0] pix);
    vec_t v;
    v.valid = 1'b1; v.sof = 1'b0; v.pix = pix; v.rdy = 1'b1;
    v.ev = 1'b0; v.ep = '0; v.ee = 1'b0; v.ec = '0; v.er = '0;
    v.ed = 1'b0; v.ers = 1'b0;
    tbl.push_back(v);
  endfunction

  function automatic void add_gap(input bit rdy);
    vec_t v;
    v.valid = 1'b0; v.sof = 1'b0; v.pix = 12'h3C3; v.rdy = rdy;
    v.ev = 1'b0; v.ep = '0; v.ee = 1'b0; v.ec = '0; v.er = '0;
    v.ed = 1'b0; v.ers = 1'b0;
    tbl.push_back(v);
  endfunction

  // Flush cycles present a live sof beat that must be ignored
  function automatic void add_flush(input int c);
    vec_t v;
    v.valid = 1'b1; v.sof = 1'b1; v.pix = 12'hFFF; v.rdy = 1'b0;
    v.ev = 1'b1; v.ep = '0; v.ee = (c == 0) || (c == PL - 1);
    v.ec = 2'(c); v.er = 2'(FR); v.ed = 1'b0; v.ers = 1'b0;
    tbl.push_back(v);
  endfunction

  function automatic void add_done();
    vec_t v;
    v.valid = 1'b0; v.sof = 1'b0; v.pix = '0; v.rdy = 1'b1;
    v.ev = 1'b0; v.ep = '0; v.ee = 1'b0; v.ec = '0; v.er = '0;
    v.ed = 1'b1; v.ers = 1'b0;
    tbl.push_back(v);
  endfunction

  // Each record: drive at a falling edge, check the result one cycle later
  task automatic run_table(input bit sel, input string name);
    obs_t o;
    tbl_valid_cnt = 0;
    foreach (tbl[i]) begin
      drive(sel, tbl[i].valid, tbl[i].sof, tbl[i].pix);
      sample(sel, o);
      chk({name, ".in_ready"}, i, 32'(o.ready), 32'(tbl[i].rdy));
      @(negedge clk);
      sample(sel, o);
      if (o.valid) tbl_valid_cnt++;
      chk({name, ".pixel_valid"}, i, 32'(o.valid), 32'(tbl[i].ev));
      chk({name, ".frame_done"}, i, 32'(o.done), 32'(tbl[i].ed));
      chk({name, ".resync_err"}, i, 32'(o.resync), 32'(tbl[i].ers));
      if (tbl[i].ev) begin
        chk({name, ".pixel_out"}, i, 32'(o.pix), 32'(tbl[i].ep));
        chk({name, ".pixel_edge"}, i, 32'(o.edg), 32'(tbl[i].ee));
        chk({name, ".col"}, i, 32'(o.col), 32'(tbl[i].ec));
        chk({name, ".row"}, i, 32'(o.row), 32'(tbl[i].er));
      end
    end
    drive(sel, 1'b0, 1'b0, '0);
    tbl.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    obs_t o;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);

    sample(1'b0, o);
    chk("reset.pixel_valid", 0, 32'(o.valid), 32'd0);
    chk("reset.pixel_out", 0, 32'(o.pix), 32'd0);
    chk("reset.pixel_edge", 0, 32'(o.edg), 32'd0);
    chk("reset.col", 0, 32'(o.col), 32'd0);
    chk("reset.row", 0, 32'(o.row), 32'd0);
    chk("reset.frame_done", 0, 32'(o.done), 32'd0);
    chk("reset.resync_err", 0, 32'(o.resync), 32'd0);
    chk("reset.busy", 0, 32'(o.busy), 32'd0);
    chk("reset.in_ready", 0, 32'(o.ready), 32'd1);
    rst = 1'b1;

    // Back-to-back frame 1..12, 4 flush zeros, frame_done 17 cycles after first accept
    for (int k = 0; k < 12; k++) add_beat(k == 0, 12'(k + 1), k % 4, k / 4, 1'b0);
    for (int k = 0; k < 4; k++) add_flush(k);
    add_done();
    add_gap(1'b1);
    run_table(1'b0, "frame");
    chk("frame.valid_count", 0, 32'(tbl_valid_cnt), 32'd16);
    sample(1'b0, o);
    chk("frame.busy_after", 0, 32'(o.busy), 32'd0);

    // Non-sof beats in IDLE are dropped
    add_drop(12'd7);
    add_drop(12'd8);
    add_drop(12'd9);
    add_beat(1'b1, 12'd5, 0, 0, 1'b0);
    run_table(1'b0, "idle_drop");
    chk("idle_drop.valid_count", 0, 32'(tbl_valid_cnt), 32'd1);
    sample(1'b0, o);
    chk("idle_drop.busy", 0, 32'(o.busy), 32'd1);
    pulse_reset();

    // Valid toggling 1,0,1,0
    for (int k = 0; k < 12; k++) begin
      add_beat(k == 0, 12'(k + 20), k % 4, k / 4, 1'b0);
      if (k < 11) add_gap(1'b1);
    end
    for (int k = 0; k < 4; k++) add_flush(k);
    add_done();
    add_gap(1'b1);
    run_table(1'b0, "gappy");
    chk("gappy.valid_count", 0, 32'(tbl_valid_cnt), 32'd16);

    // sof on the 6th beat (row 1, col 1) restarts the frame
    for (int k = 0; k < 5; k++) add_beat(k == 0, 12'(k + 31), k % 4, k / 4, 1'b0);
    add_beat(1'b1, 12'd50, 0, 0, 1'b1);
    for (int k = 1; k < 12; k++) add_beat(1'b0, 12'(k + 50), k % 4, k / 4, 1'b0);
    for (int k = 0; k < 4; k++) add_flush(k);
    add_done();
    add_gap(1'b1);
    add_gap(1'b1);
    run_table(1'b0, "resync");

    // Asynchronous reset during the second flush cycle
    for (int k = 0; k < 12; k++) add_beat(k == 0, 12'(k + 71), k % 4, k / 4, 1'b0);
    add_flush(0);
    add_flush(1);
    run_table(1'b0, "abort");
    rst = 1'b0;
    #1;
    sample(1'b0, o);
    chk("abort.async_pixel_valid", 0, 32'(o.valid), 32'd0);
    chk("abort.async_col", 0, 32'(o.col), 32'd0);
    chk("abort.async_row", 0, 32'(o.row), 32'd0);
    chk("abort.async_busy", 0, 32'(o.busy), 32'd0);
    chk("abort.async_in_ready", 0, 32'(o.ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sample(1'b0, o);
      chk("abort.hold_frame_done", k, 32'(o.done), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sample(1'b0, o);
      chk("abort.no_frame_done", k, 32'(o.done), 32'd0);
      chk("abort.no_pixel_valid", k, 32'(o.valid), 32'd0);
    end
    add_beat(1'b1, 12'd9, 0, 0, 1'b0);
    add_beat(1'b0, 12'd10, 1, 0, 1'b0);
    add_gap(1'b1);
    run_table(1'b0, "restart");

    // No flush rows: ready stays high, frame_done right after pixel 12
    for (int k = 0; k < 12; k++) add_beat(k == 0, 12'(k + 100), k % 4, k / 4, 1'b0);
    add_done();
    add_gap(1'b1);
    run_table(1'b1, "noflush");
    chk("noflush.valid_count", 0, 32'(tbl_valid_cnt), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
